uart_cmd_parser: RTL and testbench
==================================

// Module: uart_cmd_parser
// PURPOSE
//   ASCII command front-end between uart_rx and sdram_ctrl. Turns byte stream
//   "Waaaaaadddd<CR>" (write) / "Raaaaaa<CR>" (read) into one SDRAM request,
//   waits for completion, then returns an ASCII response through uart_tx.
//   Single clock domain; rx, SDRAM and tx handshakes are all synchronous to clk.
// PARAMETERS
//   ADDR_W          24          SDRAM word address width; multiple of 4 (ADDR_W/4 hex digits)
//   DATA_W          16          SDRAM data width; multiple of 4 (DATA_W/4 hex digits)
//   TIMEOUT_CYCLES  50_000_000  idle clocks before a partial command is aborted (CMD_TIMEOUT_EN only)
// PORTS
//   clk        in   1       system clock
//   rst_n      in   1       asynchronous active-low reset
//   rx_data    in   8       received byte
//   rx_valid   in   1       1-cycle strobe, rx_data valid
//   cmd_addr   out  ADDR_W  SDRAM address, stable while wr_req/rd_req high
//   cmd_wdata  out  DATA_W  SDRAM write data, stable while wr_req high
//   wr_req     out  1       write request, level, held until wr_done
//   rd_req     out  1       read request, level, held until rd_ready
//   wr_done    in   1       write complete strobe
//   rd_ready   in   1       read data valid strobe
//   rd_data    in   DATA_W  read data, sampled when rd_ready=1
//   tx_data    out  8       response byte to uart_tx
//   tx_send    out  1       1-cycle strobe, launch tx_data
//   tx_busy    in   1       uart_tx busy
//   busy       out  1       high in any state other than IDLE
//   err        out  1       1-cycle strobe on any parse error, overrun or timeout
// BEHAVIOUR
//   Reset: all outputs 0, state IDLE, digit counter 0, addr/data regs 0.
//   States: IDLE, ADDR, DATA, EOL, DISCARD, REQ_WR, REQ_RD, RESP.
//   IDLE: 'W'/'w'->ADDR(write), 'R'/'r'->ADDR(read); CR, LF, space ignored;
//     any other byte -> err, DISCARD.
//   ADDR: ADDR_W/4 hex digits, MSB first, cmd_addr <= {cmd_addr<<4, nib};
//     then write->DATA (DATA_W/4 digits, same shift), read->EOL.
//   Hex: 0-9, A-F, a-f. Non-hex in ADDR/DATA -> err, DISCARD.
//   EOL: CR or LF -> REQ_WR/REQ_RD; anything else -> err, DISCARD.
//   DISCARD: drop bytes until CR or LF, then queue "?\r\n" -> RESP.
//   REQ_WR: wr_req=1 from the cycle after EOL accepts; drop it the cycle after
//     wr_done; queue "K\r\n". REQ_RD: same with rd_req/rd_ready; capture rd_data,
//     queue DATA_W/4 uppercase hex digits MSB first + "\r\n".
//   wr_done/rd_ready outside their REQ state: ignored. Never both requests high.
//   RESP: send a byte only when tx_busy=0 and no tx_send in the previous cycle
//     (uart_tx raises busy one cycle late); after the last byte -> IDLE.
//   Overrun: rx_valid in REQ_* or RESP -> byte dropped, err pulse, state unchanged.
//   Latency: final CR -> wr_req/rd_req high = 1 cycle.
//   Reset mid-operation: requests drop immediately; in-flight SDRAM access unowned.
// CONFIGURATION
//   CMD_TIMEOUT_EN defined: counter clears on each rx_valid, runs in ADDR/DATA/EOL/DISCARD;
//     at TIMEOUT_CYCLES-1 -> err, partial command dropped, IDLE, no response.
//   Undefined: no counter; partial command waits indefinitely.
// STRUCTURE
//   Package uart_cmd_pkg: state enum; ASCII constants (CR, LF, SP, 'W', 'R', 'K', '?');
//     functions hex2nib (with valid flag) and nib2hex (uppercase).
//   Sub-module uart_resp_seq: holds up to DATA_W/4+2 queued bytes, paces tx_send
//     against tx_busy, returns done. Parser FSM in uart_cmd_parser.
// TESTING
//   "W0012AB5A5A\r" -> wr_req=1, cmd_addr=0x0012AB, cmd_wdata=0x5A5A; wr_done -> "K\r\n".
//   "r00beef\n", rd_ready with rd_data=0xC0DE -> rd_req drops; tx "C0DE\r\n".
//   "W00G..." -> err at 'G', no request; after "\r" tx "?\r\n", busy=0.
//   Bytes sent during REQ_RD -> each one err, dropped; read still completes correctly.
//   CMD_TIMEOUT_EN, TIMEOUT_CYCLES=100: "W12", idle 100 cycles -> err, IDLE; then valid read passes.
//   Reset asserted while wr_req=1 -> wr_req, tx_send, busy = 0 asynchronously.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the ASCII command parser: FSM states, response kinds,
// ASCII byte constants and hex digit conversion helpers.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_EOL,
        ST_DISCARD,
        ST_REQ_WR,
        ST_REQ_RD,
        ST_RESP
    } state_t;

    typedef enum logic [1:0] {
        RESP_OK   = 2'd0,
        RESP_ERR  = 2'd1,
        RESP_DATA = 2'd2
    } resp_kind_t;

    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_SP   = 8'h20;
    localparam logic [7:0] ASCII_W    = 8'h57;
    localparam logic [7:0] ASCII_W_LC = 8'h77;
    localparam logic [7:0] ASCII_R    = 8'h52;
    localparam logic [7:0] ASCII_R_LC = 8'h72;
    localparam logic [7:0] ASCII_K    = 8'h4B;
    localparam logic [7:0] ASCII_QM   = 8'h3F;

    // Returns {valid, nibble}; valid=0 for anything that is not 0-9, A-F, a-f.
    function automatic logic [4:0] hex2nib(input logic [7:0] c);
        logic [4:0] r;
        r = 5'b0_0000;
        if (c >= 8'h30 && c <= 8'h39) begin
            r = {1'b1, c[3:0]};
        end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
            r = {1'b1, c[3:0] + 4'd9};
        end else begin
            r = 5'b0_0000;
        end
        return r;
    endfunction

    function automatic logic [7:0] nib2hex(input logic [3:0] n);
        logic [7:0] r;
        if (n < 4'd10) begin
            r = {4'h3, n};
        end else begin
            r = 8'h37 + {4'h0, n};
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_resp_seq.sv
// Response byte sequencer: latches one ASCII response and paces it out to
// uart_tx, leaving a gap after each launch because tx_busy rises a cycle late.
module uart_resp_seq
    import uart_cmd_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [1:0]        kind,
    input  logic [DATA_W-1:0] rdata,
    input  logic              tx_busy,
    output logic [7:0]        tx_data,
    output logic              tx_send,
    output logic              done
);

    localparam int ND    = DATA_W / 4;
    localparam int NB    = ND + 2;
    localparam int IDX_W = $clog2(NB + 1);

    logic [7:0]       byte_q_r [NB];
    logic [IDX_W-1:0] idx_r;
    logic [IDX_W-1:0] len_r;
    logic             active_r;
    logic [7:0]       tx_data_r;
    logic             tx_send_r;
    logic             done_r;

    // Load a response image, then launch one byte whenever uart_tx can take it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NB; i++) begin
                byte_q_r[i] <= 8'h00;
            end
            idx_r     <= '0;
            len_r     <= '0;
            active_r  <= 1'b0;
            tx_data_r <= 8'h00;
            tx_send_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            tx_send_r <= 1'b0;
            done_r    <= 1'b0;
            if (load) begin
                active_r <= 1'b1;
                idx_r    <= '0;
                case (kind)
                    RESP_OK: begin
                        byte_q_r[0] <= ASCII_K;
                        byte_q_r[1] <= ASCII_CR;
                        byte_q_r[2] <= ASCII_LF;
                        len_r       <= IDX_W'(2'd3);
                    end
                    RESP_DATA: begin
                        for (int i = 0; i < ND; i++) begin
                            byte_q_r[i] <= nib2hex(rdata[(ND-1-i)*4 +: 4]);
                        end
                        byte_q_r[ND]   <= ASCII_CR;
                        byte_q_r[ND+1] <= ASCII_LF;
                        len_r          <= IDX_W'(NB);
                    end
                    default: begin
                        byte_q_r[0] <= ASCII_QM;
                        byte_q_r[1] <= ASCII_CR;
                        byte_q_r[2] <= ASCII_LF;
                        len_r       <= IDX_W'(2'd3);
                    end
                endcase
            end else if (active_r && !tx_busy && !tx_send_r) begin
                tx_data_r <= byte_q_r[idx_r];
                tx_send_r <= 1'b1;
                idx_r     <= idx_r + IDX_W'(1'b1);
                if (idx_r == len_r - IDX_W'(1'b1)) begin
                    active_r <= 1'b0;
                    done_r   <= 1'b1;
                end else begin
                    active_r <= 1'b1;
                end
            end else begin
                active_r <= active_r;
            end
        end
    end

    assign tx_data = tx_data_r;
    assign tx_send = tx_send_r;
    assign done    = done_r;

endmodule

// File: rtl/uart_cmd_parser.sv
// ASCII command parser: "Waaaaaadddd<CR>" / "Raaaaaa<CR>" to one SDRAM request
// plus an ASCII reply. Optional idle abort of partial commands: CMD_TIMEOUT_EN.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int ADDR_W         = 24,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [DATA_W-1:0] cmd_wdata,
    output logic              wr_req,
    output logic              rd_req,
    input  logic              wr_done,
    input  logic              rd_ready,
    input  logic [DATA_W-1:0] rd_data,
    output logic [7:0]        tx_data,
    output logic              tx_send,
    input  logic              tx_busy,
    output logic              busy,
    output logic              err
);

    localparam int AD    = ADDR_W / 4;
    localparam int DD    = DATA_W / 4;
    localparam int CNT_W = 8;

    state_t            state_r, state_next_s;
    logic              is_wr_r, is_wr_next_s;
    logic [CNT_W-1:0]  cnt_r, cnt_next_s;
    logic [ADDR_W-1:0] cmd_addr_r, addr_next_s;
    logic [DATA_W-1:0] cmd_wdata_r, wdata_next_s;
    logic              wr_req_r, rd_req_r, busy_r, err_r;
    logic              err_s;
    logic              resp_load_s;
    logic [1:0]        resp_kind_s;
    logic              resp_done_s;
    logic              tmo_hit_s;
    logic [4:0]        hex_s;
    logic              is_eol_s;

    assign hex_s    = hex2nib(rx_data);
    assign is_eol_s = (rx_data == ASCII_CR) || (rx_data == ASCII_LF);

`ifdef CMD_TIMEOUT_EN
    logic [31:0] tmo_cnt_r;
    logic        tmo_run_s;

    assign tmo_run_s = (state_r == ST_ADDR) || (state_r == ST_DATA) ||
                       (state_r == ST_EOL)  || (state_r == ST_DISCARD);
    assign tmo_hit_s = tmo_run_s && !rx_valid && (tmo_cnt_r == 32'(TIMEOUT_CYCLES - 1));

    // Idle counter for partial commands; any received byte restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_r <= 32'd0;
        end else if (rx_valid || !tmo_run_s || tmo_hit_s) begin
            tmo_cnt_r <= 32'd0;
        end else begin
            tmo_cnt_r <= tmo_cnt_r + 32'd1;
        end
    end
`else
    assign tmo_hit_s = 1'b0;
`endif

    // Parser next-state and datapath update.
    always_comb begin
        state_next_s = state_r;
        is_wr_next_s = is_wr_r;
        cnt_next_s   = cnt_r;
        addr_next_s  = cmd_addr_r;
        wdata_next_s = cmd_wdata_r;
        err_s        = 1'b0;
        resp_load_s  = 1'b0;
        resp_kind_s  = RESP_ERR;
        case (state_r)
            ST_IDLE: begin
                cnt_next_s = '0;
                if (rx_valid) begin
                    if (rx_data == ASCII_W || rx_data == ASCII_W_LC) begin
                        is_wr_next_s = 1'b1;
                        state_next_s = ST_ADDR;
                    end else if (rx_data == ASCII_R || rx_data == ASCII_R_LC) begin
                        is_wr_next_s = 1'b0;
                        state_next_s = ST_ADDR;
                    end else if (is_eol_s || rx_data == ASCII_SP) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        err_s        = 1'b1;
                        state_next_s = ST_DISCARD;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (rx_valid && hex_s[4]) begin
                    addr_next_s = {cmd_addr_r[ADDR_W-5:0], hex_s[3:0]};
                    if (cnt_r == CNT_W'(AD - 1)) begin
                        cnt_next_s   = '0;
                        state_next_s = is_wr_r ? ST_DATA : ST_EOL;
                    end else begin
                        cnt_next_s = cnt_r + CNT_W'(1'b1);
                    end
                end else if (rx_valid) begin
                    err_s        = 1'b1;
                    cnt_next_s   = '0;
                    state_next_s = ST_DISCARD;
                end else begin
                    state_next_s = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (rx_valid && hex_s[4]) begin
                    wdata_next_s = {cmd_wdata_r[DATA_W-5:0], hex_s[3:0]};
                    if (cnt_r == CNT_W'(DD - 1)) begin
                        cnt_next_s   = '0;
                        state_next_s = ST_EOL;
                    end else begin
                        cnt_next_s = cnt_r + CNT_W'(1'b1);
                    end
                end else if (rx_valid) begin
                    err_s        = 1'b1;
                    cnt_next_s   = '0;
                    state_next_s = ST_DISCARD;
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_EOL: begin
                if (rx_valid && is_eol_s) begin
                    state_next_s = is_wr_r ? ST_REQ_WR : ST_REQ_RD;
                end else if (rx_valid) begin
                    err_s        = 1'b1;
                    state_next_s = ST_DISCARD;
                end else begin
                    state_next_s = ST_EOL;
                end
            end
            ST_DISCARD: begin
                if (rx_valid && is_eol_s) begin
                    resp_load_s  = 1'b1;
                    resp_kind_s  = RESP_ERR;
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = ST_DISCARD;
                end
            end
            ST_REQ_WR: begin
                err_s = rx_valid;
                if (wr_done) begin
                    resp_load_s  = 1'b1;
                    resp_kind_s  = RESP_OK;
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = ST_REQ_WR;
                end
            end
            ST_REQ_RD: begin
                err_s = rx_valid;
                if (rd_ready) begin
                    resp_load_s  = 1'b1;
                    resp_kind_s  = RESP_DATA;
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = ST_REQ_RD;
                end
            end
            ST_RESP: begin
                err_s = rx_valid;
                if (resp_done_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
        // An idle partial command is abandoned silently apart from the err strobe.
        if (tmo_hit_s) begin
            err_s        = 1'b1;
            cnt_next_s   = '0;
            state_next_s = ST_IDLE;
        end else begin
            err_s = err_s;
        end
    end

    // State, datapath and registered outputs derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            is_wr_r     <= 1'b0;
            cnt_r       <= '0;
            cmd_addr_r  <= '0;
            cmd_wdata_r <= '0;
            wr_req_r    <= 1'b0;
            rd_req_r    <= 1'b0;
            busy_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            is_wr_r     <= is_wr_next_s;
            cnt_r       <= cnt_next_s;
            cmd_addr_r  <= addr_next_s;
            cmd_wdata_r <= wdata_next_s;
            wr_req_r    <= (state_next_s == ST_REQ_WR);
            rd_req_r    <= (state_next_s == ST_REQ_RD);
            busy_r      <= (state_next_s != ST_IDLE);
            err_r       <= err_s;
        end
    end

    uart_resp_seq #(
        .DATA_W (DATA_W)
    ) u_resp_seq (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (resp_load_s),
        .kind    (resp_kind_s),
        .rdata   (rd_data),
        .tx_busy (tx_busy),
        .tx_data (tx_data),
        .tx_send (tx_send),
        .done    (resp_done_s)
    );

    assign cmd_addr  = cmd_addr_r;
    assign cmd_wdata = cmd_wdata_r;
    assign wr_req    = wr_req_r;
    assign rd_req    = rd_req_r;
    assign busy      = busy_r;
    assign err       = err_r;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: command vector table, tx byte
// scoreboard and hand-written overrun/reset/timeout sequences.
module tb_uart_cmd_parser;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [23:0] cmd_addr;
    logic [15:0] cmd_wdata;
    logic        wr_req;
    logic        rd_req;
    logic        wr_done;
    logic        rd_ready;
    logic [15:0] rd_data;
    logic [7:0]  tx_data;
    logic        tx_send;
    logic        tx_busy;
    logic        busy;
    logic        err;

    int checks   = 0;
    int errors   = 0;
    int err_seen = 0;
    logic [7:0] exp_q [$];

    typedef struct {
        string       name;
        string       cmd;
        logic        req;
        logic        is_wr;
        logic [23:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          n_err;
        string       resp;
    } vec_t;

    vec_t vecs [9];

    uart_cmd_parser #(
        .ADDR_W         (24),
        .DATA_W         (16),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .wr_req    (wr_req),
        .rd_req    (rd_req),
        .wr_done   (wr_done),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .tx_data   (tx_data),
        .tx_send   (tx_send),
        .tx_busy   (tx_busy),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input string cmd, input logic req,
                                input logic is_wr, input logic [23:0] addr,
                                input logic [15:0] wdata, input logic [15:0] rdata,
                                input int n_err, input string resp);
        vec_t v;
        v.name = name; v.cmd = cmd; v.req = req; v.is_wr = is_wr; v.addr = addr;
        v.wdata = wdata; v.rdata = rdata; v.n_err = n_err; v.resp = resp;
        return v;
    endfunction

    // uart_tx model: busy rises one cycle after a launch and stays up 4 cycles.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_send) begin
                @(posedge clk); #1 tx_busy = 1'b1;
                repeat (4) @(posedge clk);
                #1 tx_busy = 1'b0;
            end
        end
    end

    // Output monitor: scoreboard for tx bytes, err strobe counter, request exclusivity.
    always @(negedge clk) begin
        logic [7:0] exp_b;
        if (err) err_seen++;
        if (wr_req && rd_req) begin
            checks++; errors++;
            $display("FAIL req_exclusive actual=both required=one");
        end
        if (tx_send) begin
            checks++;
            if (tx_busy) begin
                errors++;
                $display("FAIL tx_pacing actual=send_while_busy required=idle");
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL tx_unexpected actual=%0h required=none", tx_data);
            end else begin
                exp_b = exp_q.pop_front();
                if (tx_data !== exp_b) begin
                    errors++;
                    $display("FAIL tx_byte actual=%0h required=%0h", tx_data, exp_b);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1 rx_data = b; rx_valid = 1'b1;
        @(posedge clk); #1 rx_valid = 1'b0; rx_data = 8'($urandom_range(255, 0));
        @(posedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    // Last send_byte returns 1 cycle + #1 after the consuming edge; the final
    // byte therefore needs a tighter variant to check the 1-cycle request latency.
    task automatic send_str_last(input string s);
        for (int i = 0; i < s.len() - 1; i++) send_byte(s[i]);
        @(posedge clk); #1 rx_data = s[s.len()-1]; rx_valid = 1'b1;
        @(posedge clk); #1 rx_valid = 1'b0; rx_data = 8'h00;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk(name, {31'd0, busy}, 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        int e0;
        e0 = err_seen;
        for (int i = 0; i < v.resp.len(); i++) exp_q.push_back(v.resp[i]);
        send_str_last(v.cmd);
        if (v.req) begin
            chk({v.name, "_req"},   {31'd0, v.is_wr ? wr_req : rd_req}, 32'd1);
            chk({v.name, "_other"}, {31'd0, v.is_wr ? rd_req : wr_req}, 32'd0);
            chk({v.name, "_addr"},  {8'd0, cmd_addr}, {8'd0, v.addr});
            if (v.is_wr) chk({v.name, "_wdata"}, {16'd0, cmd_wdata}, {16'd0, v.wdata});
            repeat (3) @(posedge clk);
            #1;
            if (v.is_wr) wr_done = 1'b1;
            else begin rd_ready = 1'b1; rd_data = v.rdata; end
            @(posedge clk); #1 wr_done = 1'b0; rd_ready = 1'b0; rd_data = 16'hDEAD;
            chk({v.name, "_req_drop"}, {30'd0, wr_req, rd_req}, 32'd0);
        end else begin
            chk({v.name, "_no_req"}, {30'd0, wr_req, rd_req}, 32'd0);
        end
        wait_idle({v.name, "_idle"});
        chk({v.name, "_err_cnt"}, 32'(err_seen - e0), 32'(v.n_err));
        chk({v.name, "_resp_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int e0;
        vecs[0] = mk("wr_basic", "W0012AB5A5A\015", 1'b1, 1'b1, 24'h0012AB, 16'h5A5A, 16'h0000, 0, "K\015\n");
        vecs[1] = mk("rd_basic", "r00beef\n",       1'b1, 1'b0, 24'h00BEEF, 16'h0000, 16'hC0DE, 0, "C0DE\015\n");
        vecs[2] = mk("bad_addr", "W00G12\015",      1'b0, 1'b0, 24'h0,      16'h0,    16'h0,    1, "?\015\n");
        vecs[3] = mk("rd_lead",  " \nR123456\015",  1'b1, 1'b0, 24'h123456, 16'h0000, 16'h0A9F, 0, "0A9F\015\n");
        vecs[4] = mk("wr_max",   "wFFFFFFffff\n",   1'b1, 1'b1, 24'hFFFFFF, 16'hFFFF, 16'h0000, 0, "K\015\n");
        vecs[5] = mk("bad_cmd",  "X\015",           1'b0, 1'b0, 24'h0,      16'h0,    16'h0,    1, "?\015\n");
        vecs[6] = mk("short_ad", "R123\015\n",      1'b1 & 1'b0, 1'b0, 24'h0, 16'h0,  16'h0,    1, "?\015\n");
        vecs[7] = mk("bad_data", "W000000123Z\015", 1'b0, 1'b0, 24'h0,      16'h0,    16'h0,    1, "?\015\n");
        vecs[8] = mk("long_ad",  "R0000001\015",    1'b0, 1'b0, 24'h0,      16'h0,    16'h0,    1, "?\015\n");

        rst_n = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
        wr_done = 1'b0; rd_ready = 1'b0; rd_data = 16'hDEAD;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs", {27'd0, wr_req, rd_req, busy, err, tx_send}, 32'd0);
        chk("rst_addr", {8'd0, cmd_addr}, 32'd0);
        chk("rst_data", {8'd0, tx_data, cmd_wdata}, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Completion strobes outside a request state must do nothing.
        @(posedge clk); #1 wr_done = 1'b1; rd_ready = 1'b1;
        @(posedge clk); #1 wr_done = 1'b0; rd_ready = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("stray_done", {29'd0, busy, wr_req, rd_req}, 32'd0);

        // Overrun: bytes arriving while a read is outstanding are dropped with err.
        e0 = err_seen;
        exp_q.push_back("1"); exp_q.push_back("2"); exp_q.push_back("3");
        exp_q.push_back("4"); exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
        send_str_last("R00ABCD\015");
        chk("ovr_req", {31'd0, rd_req}, 32'd1);
        chk("ovr_addr", {8'd0, cmd_addr}, 32'h0000ABCD);
        send_byte("W");
        send_byte("1");
        chk("ovr_still_req", {31'd0, rd_req}, 32'd1);
        @(posedge clk); #1 rd_ready = 1'b1; rd_data = 16'h1234;
        @(posedge clk); #1 rd_ready = 1'b0; rd_data = 16'hDEAD;
        chk("ovr_req_drop", {31'd0, rd_req}, 32'd0);
        wait_idle("ovr_idle");
        chk("ovr_err_cnt", 32'(err_seen - e0), 32'd2);
        chk("ovr_resp_left", 32'(exp_q.size()), 32'd0);

`ifdef CMD_TIMEOUT_EN
        // Partial command aborted after the idle limit; no response is sent.
        begin
            int n;
            n = 0;
            send_str_last("W12");
            for (int i = 1; i <= 200; i++) begin
                @(negedge clk);
                if (err) begin n = i; break; end
            end
            chk("tmo_seen", {31'd0, n >= 98 && n <= 102}, 32'd1);
            chk("tmo_idle", {31'd0, busy}, 32'd0);
            repeat (30) @(posedge clk);
            run_vec(mk("tmo_after", "R00CAFE\015", 1'b1, 1'b0, 24'h00CAFE, 16'h0, 16'hBEEF, 0, "BEEF\015\n"));
        end
`else
        // Without the timeout a partial command simply waits for more bytes.
        e0 = err_seen;
        send_str("W12");
        repeat (200) @(posedge clk);
        #1;
        chk("wait_busy", {31'd0, busy}, 32'd1);
        chk("wait_err", 32'(err_seen - e0), 32'd0);
        run_vec(mk("resume", "3456ABCD\015", 1'b1, 1'b1, 24'h123456, 16'hABCD, 16'h0, 0, "K\015\n"));
`endif

        // Reset while a write is outstanding clears outputs without a clock edge.
        send_str_last("W0000105555\015");
        chk("rstw_req", {31'd0, wr_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstw_outs", {29'd0, wr_req, tx_send, busy}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        run_vec(mk("post_rst", "R000010\015", 1'b1, 1'b0, 24'h000010, 16'h0, 16'h7E01, 0, "7E01\015\n"));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

endmodule
